// File: rtl/cpu_ctrl_pkg.sv
// ------------------------------------------------------------------
// cpu_ctrl_pkg : shared state/command encodings for the run sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_STEP   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4
   } run_state_t;

   typedef enum logic [1:0] {
      CMD_NOP   = 2'b00,
      CMD_RUN   = 2'b01,
      CMD_STEP  = 2'b10,
      CMD_ABORT = 2'b11
   } cmd_t;

   localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;
   localparam int          DRAIN_W            = 4;

endpackage

`default_nettype wire

// File: rtl/pipe_run_ctrl_drain_counter.sv
// ------------------------------------------------------------------
// drain_counter : loadable down-counter that parks at zero
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module drain_counter
   import cpu_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [DRAIN_W-1:0] load_val,
   input  logic               en,
   output logic               zero
);

   logic [DRAIN_W-1:0] cnt_q;
   logic [DRAIN_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/pipe_run_ctrl.sv
// ------------------------------------------------------------------
// pipe_run_ctrl : run/step/halt sequencer gating PC and pipeline enables
// PIPE_RUN_CYCLE_CNT_EN adds the cycle_cnt register (else tied to 0)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pipe_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter logic [31:0] HALT_INSTR   = HALT_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd,
   input  logic [31:0] if_instr,
   output logic        pc_en,
   output logic        pipe_en,
   output logic        halted,
   output logic        done,
   output logic [2:0]  state,
   output logic [31:0] cycle_cnt
);

   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

   run_state_t state_q;
   run_state_t state_d;
   logic       done_q;
   logic       done_d;
   logic       hit;
   logic       cmd_fire;
   logic       is_abort;
   cmd_t       cmd_w;
   logic       drain_load;
   logic       drain_en;
   logic       drain_zero;

   assign cmd_w     = cmd_t'(cmd);
   assign hit       = (if_instr == HALT_INSTR);
   assign cmd_ready = (state_q != ST_STEP) && (state_q != ST_DRAIN);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign is_abort  = cmd_fire && (cmd_w == CMD_ABORT);

   assign pipe_en   = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
   // Combinational so the PC holds in the very cycle HALT sits in IF.
   assign pc_en     = pipe_en && !hit;
   assign halted    = (state_q == ST_HALTED);
   assign done      = done_q;
   assign state     = state_q;
   assign drain_en  = (state_q == ST_DRAIN);

   always_comb begin
      state_d    = state_q;
      done_d     = 1'b0;
      drain_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               case (cmd_w)
                  CMD_RUN:  state_d = ST_RUN;
                  CMD_STEP: state_d = ST_STEP;
                  default:  state_d = ST_IDLE;
               endcase
            end
         end
         ST_RUN: begin
            // Abort beats a simultaneous HALT hit; the pipe freezes undrained.
            if (is_abort) begin
               state_d = ST_IDLE;
            end else if (hit) begin
               state_d    = ST_DRAIN;
               drain_load = 1'b1;
            end
         end
         ST_STEP: begin
            if (hit) begin
               state_d    = ST_DRAIN;
               drain_load = 1'b1;
            end else begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drain_zero) begin
               state_d = ST_HALTED;
               done_d  = 1'b1;
            end
         end
         ST_HALTED: begin
            if (is_abort) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   drain_counter u_drain_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (drain_load),
      .load_val (DRAIN_LOAD),
      .en       (drain_en),
      .zero     (drain_zero)
   );

`ifdef PIPE_RUN_CYCLE_CNT_EN
   logic [31:0] cycle_cnt_q;
   logic [31:0] cycle_cnt_d;
   logic        cnt_clr;

   assign cnt_clr = (state_q == ST_HALTED) && is_abort;

   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      if (cnt_clr) begin
         cycle_cnt_d = '0;
      end else if (pipe_en) begin
         cycle_cnt_d = cycle_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
`else
   assign cycle_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_run_ctrl.sv
// ------------------------------------------------------------------
// tb_pipe_run_ctrl : scoreboard bench for pipe_run_ctrl
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_pipe_run_ctrl;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam logic [2:0]  S_IDLE = 3'd0, S_RUN = 3'd1, S_STEP = 3'd2, S_DRAIN = 3'd3, S_HALT = 3'd4;
   localparam logic [1:0]  C_NOP = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_ABORT = 2'b11;
`ifdef PIPE_RUN_CYCLE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd;
   logic [31:0] if_instr;
   logic        pc_en;
   logic        pipe_en;
   logic        halted;
   logic        done;
   logic [2:0]  state;
   logic [31:0] cycle_cnt;

   int vectors = 0;
   int errors  = 0;

   typedef struct packed {
      logic        v;
      logic [1:0]  c;
      logic        h;
      logic [39:0] e;
   } step_t;

   logic [39:0] exp_q[$];

   pipe_run_ctrl #(
      .DRAIN_CYCLES (4),
      .HALT_INSTR   (HALT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd       (cmd),
      .if_instr  (if_instr),
      .pc_en     (pc_en),
      .pipe_en   (pipe_en),
      .halted    (halted),
      .done      (done),
      .state     (state),
      .cycle_cnt (cycle_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {cycle_cnt, state, pipe_en, pc_en, done, halted, cmd_ready}.
   function automatic step_t mk(input logic v, input logic [1:0] c, input logic h,
                                input logic [2:0] s, input logic pe, input logic pc,
                                input logic dn, input logic hl, input logic rdy,
                                input int unsigned n);
      step_t t;
      t.v = v;
      t.c = c;
      t.h = h;
      t.e = {(CNT_EN ? 32'(n) : 32'd0), s, pe, pc, dn, hl, rdy};
      return t;
   endfunction

   // Non-HALT fetch stream, including a one-bit near miss of the HALT encoding.
   function automatic logic [31:0] nh(input int i);
      if ((i % 4) == 3) return 32'hFFFF_FFFE;
      return 32'h0040_0000 + 32'(i * 4);
   endfunction

   task automatic apply_reset;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd       = C_NOP;
      #2 reset = 1'b1;
      #1 reset = 1'b0;
   endtask

   task automatic test_reset;
      logic [39:0] got;
      @(negedge clk);
      #1;
      got = {cycle_cnt, state, pipe_en, pc_en, done, halted, cmd_ready};
      vectors++;
      if (got !== {32'd0, S_IDLE, 5'b00001}) begin
         errors++;
         $display("FAIL reset_held: got %b cnt %0d, want %b cnt 0", got[7:0], got[39:8], {S_IDLE, 5'b00001});
      end
      reset = 1'b0;
      @(negedge clk);
      #1;
      got = {cycle_cnt, state, pipe_en, pc_en, done, halted, cmd_ready};
      vectors++;
      if (got !== {32'd0, S_IDLE, 5'b00001}) begin
         errors++;
         $display("FAIL reset_released: got %b cnt %0d, want %b cnt 0", got[7:0], got[39:8], {S_IDLE, 5'b00001});
      end
   endtask

   task automatic test_run_halt;
      step_t seq[$];
      logic [39:0] got, want;
      apply_reset();
      seq.push_back(mk(1, C_RUN, 0, S_IDLE, 0, 0, 0, 0, 1, 0));
      for (int k = 1; k <= 4; k++) seq.push_back(mk(0, C_NOP, 0, S_RUN, 1, 1, 0, 0, 1, k - 1));
      seq.push_back(mk(0, C_NOP, 1, S_RUN, 1, 0, 0, 0, 1, 4));
      for (int k = 0; k < 4; k++) seq.push_back(mk(0, C_NOP, 1, S_DRAIN, 1, 0, 0, 0, 0, 5 + k));
      seq.push_back(mk(0, C_NOP, 1, S_HALT, 0, 0, 1, 1, 1, 9));
      seq.push_back(mk(0, C_NOP, 1, S_HALT, 0, 0, 0, 1, 1, 9));
      foreach (seq[i]) begin
         @(negedge clk);
         cmd_valid = seq[i].v;
         cmd       = seq[i].c;
         if_instr  = seq[i].h ? HALT : nh(i);
         exp_q.push_back(seq[i].e);
         #1;
         want = exp_q.pop_front();
         got  = {cycle_cnt, state, pipe_en, pc_en, done, halted, cmd_ready};
         vectors++;
         if (got !== want) begin
            errors++;
            $display("FAIL run_halt cyc %0d: st/pipe/pc/done/halt/rdy got %b cnt %0d, want %b cnt %0d",
                     i, got[7:0], got[39:8], want[7:0], want[39:8]);
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic test_halted_cmds;
      step_t seq[$];
      logic [39:0] got, want;
      seq.push_back(mk(1, C_RUN,   1, S_HALT, 0, 0, 0, 1, 1, 9));
      seq.push_back(mk(1, C_STEP,  1, S_HALT, 0, 0, 0, 1, 1, 9));
      seq.push_back(mk(1, C_NOP,   1, S_HALT, 0, 0, 0, 1, 1, 9));
      seq.push_back(mk(1, C_ABORT, 1, S_HALT, 0, 0, 0, 1, 1, 9));
      seq.push_back(mk(0, C_NOP,   1, S_IDLE, 0, 0, 0, 0, 1, 0));
      seq.push_back(mk(0, C_NOP,   0, S_IDLE, 0, 0, 0, 0, 1, 0));
      foreach (seq[i]) begin
         @(negedge clk);
         cmd_valid = seq[i].v;
         cmd       = seq[i].c;
         if_instr  = seq[i].h ? HALT : nh(i);
         exp_q.push_back(seq[i].e);
         #1;
         want = exp_q.pop_front();
         got  = {cycle_cnt, state, pipe_en, pc_en, done, halted, cmd_ready};
         vectors++;
         if (got !== want) begin
            errors++;
            $display("FAIL halted_cmds cyc %0d: st/pipe/pc/done/halt/rdy got %b cnt %0d, want %b cnt %0d",
                     i, got[7:0], got[39:8], want[7:0], want[39:8]);
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic test_steps;
      step_t seq[$];
      logic [39:0] got, want;
      apply_reset();
      seq.push_back(mk(1, C_STEP, 0, S_IDLE, 0, 0, 0, 0, 1, 0));
      for (int k = 0; k < 3; k++) begin
         seq.push_back(mk(1, C_RUN, 0, S_STEP, 1, 1, 0, 0, 0, k));
         seq.push_back(mk(k < 2, C_STEP, 0, S_IDLE, 0, 0, 1, 0, 1, k + 1));
      end
      seq.push_back(mk(0, C_NOP, 0, S_IDLE, 0, 0, 0, 0, 1, 3));
      foreach (seq[i]) begin
         @(negedge clk);
         cmd_valid = seq[i].v;
         cmd       = seq[i].c;
         if_instr  = seq[i].h ? HALT : nh(i);
         exp_q.push_back(seq[i].e);
         #1;
         want = exp_q.pop_front();
         got  = {cycle_cnt, state, pipe_en, pc_en, done, halted, cmd_ready};
         vectors++;
         if (got !== want) begin
            errors++;
            $display("FAIL steps cyc %0d: st/pipe/pc/done/halt/rdy got %b cnt %0d, want %b cnt %0d",
                     i, got[7:0], got[39:8], want[7:0], want[39:8]);
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic test_step_on_halt;
      step_t seq[$];
      logic [39:0] got, want;
      apply_reset();
      seq.push_back(mk(1, C_STEP, 1, S_IDLE, 0, 0, 0, 0, 1, 0));
      seq.push_back(mk(1, C_ABORT, 1, S_STEP, 1, 0, 0, 0, 0, 0));
      for (int k = 0; k < 4; k++) seq.push_back(mk(1, C_ABORT, 1, S_DRAIN, 1, 0, 0, 0, 0, 1 + k));
      seq.push_back(mk(0, C_NOP, 1, S_HALT, 0, 0, 1, 1, 1, 5));
      seq.push_back(mk(0, C_NOP, 1, S_HALT, 0, 0, 0, 1, 1, 5));
      foreach (seq[i]) begin
         @(negedge clk);
         cmd_valid = seq[i].v;
         cmd       = seq[i].c;
         if_instr  = seq[i].h ? HALT : nh(i);
         exp_q.push_back(seq[i].e);
         #1;
         want = exp_q.pop_front();
         got  = {cycle_cnt, state, pipe_en, pc_en, done, halted, cmd_ready};
         vectors++;
         if (got !== want) begin
            errors++;
            $display("FAIL step_on_halt cyc %0d: st/pipe/pc/done/halt/rdy got %b cnt %0d, want %b cnt %0d",
                     i, got[7:0], got[39:8], want[7:0], want[39:8]);
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic test_abort_vs_hit;
      step_t seq[$];
      logic [39:0] got, want;
      apply_reset();
      seq.push_back(mk(1, C_RUN,   0, S_IDLE, 0, 0, 0, 0, 1, 0));
      seq.push_back(mk(1, C_STEP,  0, S_RUN,  1, 1, 0, 0, 1, 0));
      seq.push_back(mk(1, C_ABORT, 1, S_RUN,  1, 0, 0, 0, 1, 1));
      seq.push_back(mk(0, C_NOP,   1, S_IDLE, 0, 0, 0, 0, 1, 2));
      seq.push_back(mk(0, C_NOP,   1, S_IDLE, 0, 0, 0, 0, 1, 2));
      foreach (seq[i]) begin
         @(negedge clk);
         cmd_valid = seq[i].v;
         cmd       = seq[i].c;
         if_instr  = seq[i].h ? HALT : nh(i);
         exp_q.push_back(seq[i].e);
         #1;
         want = exp_q.pop_front();
         got  = {cycle_cnt, state, pipe_en, pc_en, done, halted, cmd_ready};
         vectors++;
         if (got !== want) begin
            errors++;
            $display("FAIL abort_vs_hit cyc %0d: st/pipe/pc/done/halt/rdy got %b cnt %0d, want %b cnt %0d",
                     i, got[7:0], got[39:8], want[7:0], want[39:8]);
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic test_async_reset;
      step_t seq[$];
      step_t seq2[$];
      logic [39:0] got, want;
      apply_reset();
      seq.push_back(mk(1, C_RUN, 0, S_IDLE, 0, 0, 0, 0, 1, 0));
      seq.push_back(mk(0, C_NOP, 0, S_RUN,  1, 1, 0, 0, 1, 0));
      seq.push_back(mk(0, C_NOP, 0, S_RUN,  1, 1, 0, 0, 1, 1));
      seq.push_back(mk(0, C_NOP, 1, S_RUN,  1, 0, 0, 0, 1, 2));
      seq.push_back(mk(0, C_NOP, 1, S_DRAIN, 1, 0, 0, 0, 0, 3));
      seq.push_back(mk(0, C_NOP, 1, S_DRAIN, 1, 0, 0, 0, 0, 4));
      foreach (seq[i]) begin
         @(negedge clk);
         cmd_valid = seq[i].v;
         cmd       = seq[i].c;
         if_instr  = seq[i].h ? HALT : nh(i);
         exp_q.push_back(seq[i].e);
         #1;
         want = exp_q.pop_front();
         got  = {cycle_cnt, state, pipe_en, pc_en, done, halted, cmd_ready};
         vectors++;
         if (got !== want) begin
            errors++;
            $display("FAIL async_pre cyc %0d: st/pipe/pc/done/halt/rdy got %b cnt %0d, want %b cnt %0d",
                     i, got[7:0], got[39:8], want[7:0], want[39:8]);
         end
      end
      #1 reset = 1'b1;
      #1;
      got = {cycle_cnt, state, pipe_en, pc_en, done, halted, cmd_ready};
      vectors++;
      if (got !== {32'd0, S_IDLE, 5'b00001}) begin
         errors++;
         $display("FAIL async_reset_now: got %b cnt %0d, want %b cnt 0", got[7:0], got[39:8], {S_IDLE, 5'b00001});
      end
      @(posedge clk);
      #3 reset = 1'b0;
      seq2.push_back(mk(1, C_RUN, 1, S_IDLE, 0, 0, 0, 0, 1, 0));
      seq2.push_back(mk(0, C_NOP, 1, S_RUN,  1, 0, 0, 0, 1, 0));
      for (int k = 0; k < 4; k++) seq2.push_back(mk(0, C_NOP, 1, S_DRAIN, 1, 0, 0, 0, 0, 1 + k));
      seq2.push_back(mk(0, C_NOP, 1, S_HALT, 0, 0, 1, 1, 1, 5));
      seq2.push_back(mk(0, C_NOP, 1, S_HALT, 0, 0, 0, 1, 1, 5));
      foreach (seq2[i]) begin
         @(negedge clk);
         cmd_valid = seq2[i].v;
         cmd       = seq2[i].c;
         if_instr  = seq2[i].h ? HALT : nh(i);
         exp_q.push_back(seq2[i].e);
         #1;
         want = exp_q.pop_front();
         got  = {cycle_cnt, state, pipe_en, pc_en, done, halted, cmd_ready};
         vectors++;
         if (got !== want) begin
            errors++;
            $display("FAIL async_post cyc %0d: st/pipe/pc/done/halt/rdy got %b cnt %0d, want %b cnt %0d",
                     i, got[7:0], got[39:8], want[7:0], want[39:8]);
         end
      end
      cmd_valid = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd       = C_NOP;
      if_instr  = 32'h0;
      test_reset();
      test_run_halt();
      test_halted_cmds();
      test_steps();
      test_step_on_halt();
      test_abort_vs_hit();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors %0d", errors);
      $fatal(1);
   end

endmodule

`default_nettype wire
